banked_buffer: RTL and testbench

//  Two-bank on-chip word buffer: accepts 32-bit words one per cycle (STORE) and streams
//  64-bit rows, one bank-pair per cycle (STREAM). Used as the operand staging buffer

---
 rtl/banked_buffer_pkg.sv | 17 +
 rtl/banked_buffer_bank.sv | 64 ++++++
 rtl/banked_buffer.sv | 90 +++++++++
 tb/tb_banked_buffer.sv | 155 +++++++++++++++
 4 files changed

// File: rtl/banked_buffer_pkg.sv
// Shared types and defaults for the two-bank 32->64 staging buffer.
// Optional per-word valid tracking: define BANKED_BUFFER_VALID_EN.
package banked_buffer_pkg;

  localparam int ADDR_W_DEF = 14;
  localparam int DATA_W_DEF = 32;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_STORE  = 2'b01,
    ST_STREAM = 2'b10
  } state_e;

  typedef logic [ADDR_W_DEF-1:0] word_addr_t;
  typedef logic [ADDR_W_DEF-2:0] row_addr_t;

endpackage

// File: rtl/banked_buffer_bank.sv
// One single-port bank: sync write, sync registered read.
// BANKED_BUFFER_VALID_EN adds a reset-cleared valid bit per row.
module banked_buffer_bank
  import banked_buffer_pkg::*;
#(
  parameter int ROW_W  = ADDR_W_DEF - 1,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ROW_W-1:0]  row_i,
  input  logic              we_i,
  input  logic              re_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] rdata_o
);

  localparam int DEPTH = 2 ** ROW_W;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rdata_q;
  logic [DATA_W-1:0] rdata_d;

  // Plain RAM: contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem[row_i] <= wdata_i;
    end
  end

`ifdef BANKED_BUFFER_VALID_EN
  logic [DEPTH-1:0] vld_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= '0;
    end else if (we_i) begin
      vld_q[row_i] <= 1'b1;
    end
  end

  always_comb begin
    rdata_d = '0;
    if (vld_q[row_i]) begin
      rdata_d = mem[row_i];
    end
  end
`else
  always_comb begin
    rdata_d = mem[row_i];
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_q <= '0;
    end else if (re_i) begin
      rdata_q <= rdata_d;
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/banked_buffer.sv
// Two-bank word buffer: 32-bit STORE path, 64-bit row STREAM path.
// Build option: BANKED_BUFFER_VALID_EN (per-word valid bits).
module banked_buffer
  import banked_buffer_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [DATA_W-1:0]   data_in,
  input  logic [ADDR_W-1:0]   addr,
  input  logic [1:0]          state,
  output logic [2*DATA_W-1:0] data_out
);

  localparam int ROW_W = ADDR_W - 1;

  logic [ADDR_W-1:0] wr_off_q, wr_off_d;
  logic [ROW_W-1:0]  rd_off_q, rd_off_d;
  logic [ADDR_W-1:0] waddr;
  logic [ROW_W-1:0]  rrow;
  logic [ROW_W-1:0]  brow;
  logic              is_store;
  logic              is_stream;
  logic [1:0]        we;
  logic [DATA_W-1:0] rdata0;
  logic [DATA_W-1:0] rdata1;

  // Reserved encoding falls through to idle.
  always_comb begin
    is_store  = 1'b0;
    is_stream = 1'b0;
    unique case (1'b1)
      (state == ST_STORE):  is_store  = 1'b1;
      (state == ST_STREAM): is_stream = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    waddr    = addr + wr_off_q;
    rrow     = addr[ADDR_W-1:1] + rd_off_q;
    brow     = is_store ? waddr[ADDR_W-1:1] : rrow;
    we[0]    = is_store & rst & ~waddr[0];
    we[1]    = is_store & rst & waddr[0];
    wr_off_d = is_store ? wr_off_q + ADDR_W'(1) : '0;
    rd_off_d = is_stream ? rd_off_q + ROW_W'(1) : '0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_off_q <= '0;
      rd_off_q <= '0;
    end else begin
      wr_off_q <= wr_off_d;
      rd_off_q <= rd_off_d;
    end
  end

  // Each bank's read register doubles as its half of data_out.
  banked_buffer_bank #(
    .ROW_W  (ROW_W),
    .DATA_W (DATA_W)
  ) u_bank0 (
    .clk     (clk),
    .rst_n   (rst),
    .row_i   (brow),
    .we_i    (we[0]),
    .re_i    (is_stream),
    .wdata_i (data_in),
    .rdata_o (rdata0)
  );

  banked_buffer_bank #(
    .ROW_W  (ROW_W),
    .DATA_W (DATA_W)
  ) u_bank1 (
    .clk     (clk),
    .rst_n   (rst),
    .row_i   (brow),
    .we_i    (we[1]),
    .re_i    (is_stream),
    .wdata_i (data_in),
    .rdata_o (rdata1)
  );

  assign data_out = {rdata1, rdata0};

endmodule

// File: tb/tb_banked_buffer.sv
// Scoreboard bench for banked_buffer (either build of
// BANKED_BUFFER_VALID_EN).
module tb_banked_buffer;

  typedef struct {
    string       tag;
    logic [63:0] exp;
    logic [63:0] mask;
  } sb_t;

  localparam logic [63:0] ALL = 64'hFFFFFFFF_FFFFFFFF;
  localparam logic [63:0] LO  = 64'h00000000_FFFFFFFF;
  localparam logic [63:0] HI  = 64'hFFFFFFFF_00000000;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] data_in;
  logic [13:0] addr;
  logic [1:0]  state;
  logic [63:0] data_out;

  int  n_chk = 0;
  int  n_err = 0;
  sb_t sb[$];

  banked_buffer dut (
    .clk      (clk),
    .rst      (rst),
    .data_in  (data_in),
    .addr     (addr),
    .state    (state),
    .data_out (data_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic cyc(input logic [1:0] st, input logic [13:0] a,
                     input logic [31:0] d, input bit cmp,
                     input logic [63:0] exp, input logic [63:0] mask,
                     input string tag);
    sb_t e;
    state   = st;
    addr    = a;
    data_in = d;
    if (cmp) sb.push_back('{tag, exp, mask});
    @(posedge clk);
    #1;
    if (cmp) begin
      e = sb.pop_front();
      chk(e.tag, data_out & e.mask, e.exp & e.mask);
    end
  endtask

  task automatic store(input logic [13:0] a, input logic [31:0] d);
    cyc(2'b01, a, d, 1'b0, '0, '0, "");
  endtask

  task automatic idle(input logic [1:0] st);
    cyc(st, '0, '0, 1'b0, '0, '0, "");
  endtask

  task automatic stream(input logic [13:0] a, input logic [63:0] exp,
                        input logic [63:0] mask, input string tag);
    cyc(2'b10, a, '0, 1'b1, exp, mask, tag);
  endtask

  initial begin
    rst     = 1'b0;
    state   = 2'b10;
    addr    = '0;
    data_in = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_hold", data_out, '0);
    rst = 1'b1;
    cyc(2'b00, '0, '0, 1'b1, '0, ALL, "rst_idle0");
    cyc(2'b00, '0, '0, 1'b1, '0, ALL, "rst_idle1");

    store(14'h0, 32'hDEADBEEF);
    store(14'h0, 32'hCAFEBABE);
    idle(2'b00);
    stream(14'h0, 64'hCAFEBABE_DEADBEEF, ALL, "t2_row");
    cyc(2'b00, '0, '0, 1'b1, 64'hCAFEBABE_DEADBEEF, ALL, "t2_hold0");
    cyc(2'b00, '0, '0, 1'b1, 64'hCAFEBABE_DEADBEEF, ALL, "t2_hold1");

    // Reset lands mid-burst; writes must restart at base+0.
    store(14'h0, 32'h55555555);
    data_in = 32'h77777777;
    rst     = 1'b0;
    #2;
    chk("rst_async", data_out, '0);
    @(posedge clk);
    #1;
    chk("rst_mid", data_out, '0);
    rst = 1'b1;
    store(14'h0, 32'hAABBCCDD);
    idle(2'b00);
`ifdef BANKED_BUFFER_VALID_EN
    stream(14'h0, 64'h00000000_AABBCCDD, ALL, "t5_row");
`else
    stream(14'h0, 64'hCAFEBABE_AABBCCDD, ALL, "t5_row");
`endif
    idle(2'b00);

    for (int i = 0; i < 4; i++) store(14'h0, 32'(i + 1));
    idle(2'b00);
    stream(14'h0, 64'h00000002_00000001, ALL, "t3_row0");
    stream(14'h0, 64'h00000004_00000003, ALL, "t3_row1");
    idle(2'b00);
    stream(14'h1, 64'h00000002_00000001, ALL, "t3_lsb_ign");
    idle(2'b00);

    store(14'h3FFF, 32'h11111111);
    store(14'h3FFF, 32'h22222222);
    idle(2'b00);
    stream(14'h0, 64'h0000000_22222222, LO, "t4_lo");
    idle(2'b00);
    stream(14'h3FFE, 64'h11111111_00000000, HI, "t4_hi");
    stream(14'h3FFE, 64'h00000002_22222222, ALL, "t4_rowwrap");

    store(14'h100, 32'h000000A0);
    for (int i = 0; i < 3; i++)
      cyc(2'b11, 14'h100, 32'hBAD0BAD0, 1'b1,
          64'h00000002_22222222, ALL, "t6_rsv");
    store(14'h100, 32'h000000B0);
    store(14'h100, 32'h000000B1);
    idle(2'b00);
    stream(14'h100, 64'h000000B1_000000B0, ALL, "t6_restart");

    // Switch straight from STORE to STREAM.
    store(14'h200, 32'h12345678);
    store(14'h200, 32'h9ABCDEF0);
    stream(14'h200, 64'h9ABCDEF0_12345678, ALL, "st2sr");
    idle(2'b00);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got 1 exp 0");
    $fatal(1, "timeout");
  end

endmodule
